// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-store write bus of the stream loader.
// master = loader side, slave = stream source / instruction store side.
interface imem_stream_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_stream_loader.sv
// Fills the instruction store from a little-endian byte stream while holding the CPU.
// Optional macro IMEM_LOADER_CKSUM_EN: a trailing 32-bit checksum word is verified against the data sum.
module imem_stream_loader #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     word_count,
    imem_stream_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 cpu_hold
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
    logic [23:0]        word_buf_q, word_buf_d;
    logic [CNT_W-1:0]   wc_q, wc_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               error_q, error_d;
    logic               in_ready_q, busy_q, done_q, hold_q;
    logic               streaming_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [31:0]        sum_q, sum_d;
`endif

    logic               accept;
    logic               lane3;
    logic               wc_ok;
    logic               last_word;
    logic [31:0]        assembled;

    assign accept    = bus.in_valid && in_ready_q;
    assign lane3     = accept && (byte_idx_q == 2'd3);
    assign wc_ok     = (word_count != '0) && (word_count <= CNT_W'(DEPTH));
    assign last_word = (CNT_W'(word_idx_q) + CNT_W'(1)) == wc_q;
    assign assembled = {bus.in_data, word_buf_q};

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        word_buf_d  = word_buf_q;
        wc_d        = wc_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        error_d     = error_q;
        streaming_d = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
        sum_d       = sum_q;
`endif

        if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
                2'd0:    word_buf_d[7:0]   = bus.in_data;
                2'd1:    word_buf_d[15:8]  = bus.in_data;
                2'd2:    word_buf_d[23:16] = bus.in_data;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    byte_idx_d = 2'd0;
                    word_idx_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_d      = '0;
`endif
                    if (wc_ok) begin
                        state_d = S_LOAD;
                        wc_d    = word_count;
                        error_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (lane3) begin
                    we_d    = 1'b1;
                    addr_d  = 32'({word_idx_q, 2'b00});
                    wdata_d = assembled;
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_d   = sum_q + assembled;
`endif
                    if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        word_idx_d = word_idx_q + ADDR_W'(1);
                    end
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (lane3) begin
                    state_d = S_DONE;
                    error_d = (assembled != sum_q);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        streaming_d = (state_d == S_LOAD);
`ifdef IMEM_LOADER_CKSUM_EN
        streaming_d = streaming_d || (state_d == S_CKSUM);
`endif
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 2'd0;
            word_idx_q <= '0;
            word_buf_q <= '0;
            wc_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_q     <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            word_buf_q <= word_buf_d;
            wc_q       <= wc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
            in_ready_q <= streaming_d;
            busy_q     <= streaming_d;
            done_q     <= (state_d == S_DONE);
            hold_q     <= (state_d != S_DONE);
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign cpu_hold       = hold_q;

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Write-side counterpart of the read-only instruction memory: fills the instruction store from a byte stream before the pipeline runs.
- Accepts bytes over a valid/ready handshake and assembles them little-endian into 32-bit words.
- Drives a one-cycle write strobe with a byte address, matching the PCF-style word-aligned addressing.
- Holds the processor stalled until the load completes.

Parameters:
- DEPTH, 256, number of 32-bit words in the instruction store.
- ADDR_W, 8, word-index width; must equal clog2(DEPTH).
- CNT_W, 9, width of word_count; must be able to represent the value DEPTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- word_count  input  CNT_W  number of words to load; sampled with start.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte; a byte transfers when in_valid&&in_ready.
- imem_we  output  1  one-cycle write strobe to the instruction store.
- imem_addr  output  32  byte address of the write, equal to {word_idx, 2'b00} zero-extended.
- imem_wdata  output  32  assembled word.
- busy  output  1  high while in LOAD (or CKSUM).
- done  output  1  high while in DONE.
- error  output  1  latched fault flag; cleared on the next accepted start.
- cpu_hold  output  1  stalls the processor; high in every state except DONE.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, cpu_hold=1. State returns to IDLE.
- States: IDLE, LOAD, CKSUM (feature only), DONE.
- IDLE:
  - start with 1<=word_count<=DEPTH -> LOAD; byte_idx=0, word_idx=0, error cleared.
  - start with word_count==0 or >DEPTH -> DONE with error=1 and no writes.
- LOAD:
  - in_ready=1 continuously, including during write cycles.
  - Each accepted byte goes to lane byte_idx (byte 0 -> bits[7:0]); byte_idx increments modulo 4.
  - Write: on the edge accepting lane 3, imem_we=1 for exactly the next cycle, with imem_addr = word_idx<<2 and imem_wdata = the assembled word. word_idx then increments.
  - imem_addr/imem_wdata hold their last values when imem_we=0.
  - Back-to-back bytes at one per cycle are sustained; peak rate is one word per 4 cycles.
  - When in_valid is low, the state holds and no write occurs.
- Last word: the edge accepting its lane 3 moves to DONE (or CKSUM). Its imem_we cycle coincides with the first DONE/CKSUM cycle.
- DONE:
  - in_ready=0, cpu_hold=0, done=1.
  - Stays until start; start restarts exactly as from IDLE.
- start while in LOAD/CKSUM is ignored.
- rst mid-load: a partial word is discarded, no write is issued, and already-written words are not restored.
- word_idx never exceeds word_count-1, so there is no wrap.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN
- Defined:
  - A 32-bit wrap-around sum of all assembled data words is kept.
  - After the last data word, state CKSUM accepts 4 more bytes (little-endian) with in_ready=1 and produces no imem_we.
  - On the 4th byte -> DONE; error=1 if the received value does not equal the sum.
- Not defined: no CKSUM state; error is set only by an invalid word_count.

Test Plan:
- Reset, then start with word_count=2 and bytes 13 00 00 00 93 00 10 00 streamed back-to-back -> two single-cycle imem_we strobes: addr 0x0/wdata 0x00000013, then addr 0x4/wdata 0x00100093. done=1 and cpu_hold=0 from the cycle of the second strobe.
- Same stream with in_valid toggled 1/0 every cycle -> identical writes. Each strobe occurs exactly one cycle after the 4th byte is accepted, and no spurious strobes appear.
- start with word_count=0, then separately word_count=257 -> DONE and error=1 both times, with no imem_we. A following valid start with word_count=1 clears error.
- word_count=256 with a full stream -> last write at addr 0x3FC, with no wrap back to 0.
- rst asserted after 6 of 8 bytes -> only the addr 0x0 write occurs. Outputs take reset values and cpu_hold=1. A start during LOAD has no effect.
- With IMEM_LOADER_CKSUM_EN: load 0x00000013 and 0x00100093, then checksum bytes A6 00 10 00 -> done, error=0. Checksum 00 00 00 00 -> error=1.
